// File: rtl/alu_control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) then a three-register ALU
// execute (T3-T5), emitting one step of datapath strobes per clock.
module alu_control_sequencer #(
    parameter int unsigned RCOUNT_W = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                ADD,
    output logic                SUB,
    output logic                AND,
    output logic                OR,
    output logic [15:0]         Rin,
    output logic [15:0]         Rout,
    output logic                run,
    output logic [3:0]          state,
    output logic [RCOUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_HALT = 4'd7
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_e              state_q, state_d;
    logic                t1_wait_q, t1_wait_d;
    logic [RCOUNT_W-1:0] count_q, count_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);

    assign state       = state_q;
    assign instr_count = count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_RST;
            t1_wait_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t1_wait_d = 1'b0;
        count_d   = count_q;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ADD       = 1'b0;
        SUB       = 1'b0;
        AND       = 1'b0;
        OR        = 1'b0;
        Rin       = '0;
        Rout      = '0;
        run       = 1'b1;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // t1_wait_q marks repeat cycles so the PC loads only once
                Zlowout = 1'b1;
                PCin    = ~t1_wait_q;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_d = S_T2;
                else           t1_wait_d = 1'b1;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    Rout    = 16'h0001 << rb;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                Rout    = 16'h0001 << rc;
                Zin     = 1'b1;
                ADD     = (opcode == OP_ADD);
                SUB     = (opcode == OP_SUB);
                AND     = (opcode == OP_AND);
                OR      = (opcode == OP_OR);
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Rin     = 16'h0001 << ra;
                count_d = count_q + RCOUNT_W'(1);
                state_d = S_T0;
            end
            S_HALT: begin
                run     = 1'b0;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer with a small register/Y/Z
// datapath model so ALU results can be checked end to end.
module tb_alu_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b1;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
    logic        MDRout, IRin, Yin, ADD, SUB, AND, OR;
    logic [15:0] Rin, Rout;
    logic        run;
    logic [3:0]  state;
    logic [3:0]  instr_count;

    int errors = 0;
    int checks = 0;

    // {PCout,MARin,IncPC,Zin,Zlowout,PCin,Read,MDRin,MDRout,IRin,Yin,ADD,SUB,AND,OR}
    logic [14:0] strb;
    assign strb = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                   MDRout, IRin, Yin, ADD, SUB, AND, OR};

    alu_control_sequencer #(.RCOUNT_W(4)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .Rin(Rin), .Rout(Rout), .run(run), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Datapath model: bus from Rout, Y and Z registers, register file
    logic [31:0] regs [16];
    logic [31:0] y_m, z_m, bus_v;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always_comb begin
        bus_v = '0;
        for (int i = 0; i < 16; i++) if (Rout[i]) bus_v = regs[i];
    end

    always @(posedge clk) begin
        if (Yin) y_m <= bus_v;
        if (Zin) begin
            if (ADD)      z_m <= y_m + bus_v;
            else if (SUB) z_m <= y_m - bus_v;
            else if (AND) z_m <= y_m & bus_v;
            else if (OR)  z_m <= y_m | bus_v;
        end
        for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= z_m;
        if (pl_en) regs[pl_idx] <= pl_val;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; mem_ready = 1'b1; ir = '0;
        pl_en = 1'b1; pl_idx = 4'd2; pl_val = 32'd15;
        step();
        pl_idx = 4'd3; pl_val = 32'd18;
        step();
        pl_en = 1'b0;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0h exp=0", state); end
        checks++; if (strb !== 15'h0) begin errors++; $display("FAIL reset_strobes got=%0h exp=0", strb); end
        checks++; if (Rin !== 16'h0 || Rout !== 16'h0) begin errors++; $display("FAIL reset_rsel got=%0h/%0h exp=0/0", Rin, Rout); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL reset_run got=%0b exp=1", run); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        clr = 1'b0;
        step();
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL reset_to_t0 got=%0h exp=1", state); end
    endtask

    task automatic test_and_instr();
        logic [3:0]  es_st [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [14:0] es_sb [6] = '{15'h7800, 15'h0780, 15'h0060, 15'h0010, 15'h0802, 15'h0400};
        logic [15:0] es_ro [6] = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0008, 16'h0};
        logic [15:0] es_ri [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002};
        ir = 32'h28918000;
        for (int i = 0; i < 6; i++) begin
            checks++; if (state !== es_st[i]) begin errors++; $display("FAIL and_state[%0d] got=%0h exp=%0h", i, state, es_st[i]); end
            checks++; if (strb !== es_sb[i]) begin errors++; $display("FAIL and_strobes[%0d] got=%0h exp=%0h", i, strb, es_sb[i]); end
            checks++; if (Rout !== es_ro[i]) begin errors++; $display("FAIL and_rout[%0d] got=%0h exp=%0h", i, Rout, es_ro[i]); end
            checks++; if (Rin !== es_ri[i]) begin errors++; $display("FAIL and_rin[%0d] got=%0h exp=%0h", i, Rin, es_ri[i]); end
            step();
        end
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL and_back_t0 got=%0h exp=1", state); end
        checks++; if (instr_count !== 4'd1) begin errors++; $display("FAIL and_count got=%0d exp=1", instr_count); end
    endtask

    task automatic test_sub_instr();
        ir = 32'h20918000;
        for (int i = 0; i < 6; i++) begin
            checks++; if ({strb[3], strb[1], strb[0]} !== 3'b000) begin errors++; $display("FAIL sub_other_fn[%0d] got=%0b exp=000", i, {strb[3], strb[1], strb[0]}); end
            checks++; if (SUB !== (i == 4)) begin errors++; $display("FAIL sub_strobe[%0d] got=%0b exp=%0b", i, SUB, (i == 4)); end
            step();
        end
        checks++; if (regs[1] !== 32'hFFFFFFFD) begin errors++; $display("FAIL sub_result got=%0h exp=fffffffd", regs[1]); end
        checks++; if (instr_count !== 4'd2) begin errors++; $display("FAIL sub_count got=%0d exp=2", instr_count); end
    endtask

    task automatic test_t1_wait();
        ir = 32'h18918000;
        mem_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (state !== 4'd2) begin errors++; $display("FAIL wait_state[%0d] got=%0h exp=2", k, state); end
            checks++; if (strb !== ((k == 0) ? 15'h0780 : 15'h0580)) begin errors++; $display("FAIL wait_strobes[%0d] got=%0h exp=%0h", k, strb, ((k == 0) ? 15'h0780 : 15'h0580)); end
            mem_ready = (k == 3);
            step();
        end
        checks++; if (state !== 4'd3 || strb !== 15'h0060) begin errors++; $display("FAIL wait_to_t2 got=%0h/%0h exp=3/60", state, strb); end
        step(); step();
        checks++; if (strb !== 15'h0808) begin errors++; $display("FAIL add_strobes got=%0h exp=808", strb); end
        step(); step();
        checks++; if (regs[1] !== 32'd33) begin errors++; $display("FAIL add_result got=%0h exp=21", regs[1]); end
        checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL add_count got=%0d exp=3", instr_count); end
    endtask

    task automatic test_nop();
        logic [3:0] es_st [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        ir = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== es_st[i]) begin errors++; $display("FAIL nop_state[%0d] got=%0h exp=%0h", i, state, es_st[i]); end
            checks++; if (Rin !== 16'h0 || Rout !== 16'h0) begin errors++; $display("FAIL nop_rsel[%0d] got=%0h/%0h exp=0/0", i, Rin, Rout); end
            if (i < 4) step();
        end
        checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL nop_count got=%0d exp=3", instr_count); end
    endtask

    task automatic test_or_instr();
        ir = 32'h30918000;
        step(); step(); step(); step();
        checks++; if (strb !== 15'h0801 || Rout !== 16'h0008) begin errors++; $display("FAIL or_t4 got=%0h/%0h exp=801/8", strb, Rout); end
        step(); step();
        checks++; if (regs[1] !== 32'h1F) begin errors++; $display("FAIL or_result got=%0h exp=1f", regs[1]); end
        checks++; if (instr_count !== 4'd4) begin errors++; $display("FAIL or_count got=%0d exp=4", instr_count); end
    endtask

    task automatic test_clr_mid();
        logic [31:0] prev;
        prev = regs[1];
        ir = 32'h18918000;
        step(); step(); step(); step();
        checks++; if (state !== 4'd5) begin errors++; $display("FAIL clrmid_in_t4 got=%0h exp=5", state); end
        clr = 1'b1;
        step();
        checks++; if (state !== 4'd0 || run !== 1'b1) begin errors++; $display("FAIL clrmid_rst got=%0h/%0b exp=0/1", state, run); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL clrmid_count got=%0d exp=0", instr_count); end
        checks++; if (Rin !== 16'h0 || strb !== 15'h0) begin errors++; $display("FAIL clrmid_quiet got=%0h/%0h exp=0/0", Rin, strb); end
        clr = 1'b0;
        step();
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL clrmid_t0 got=%0h exp=1", state); end
        checks++; if (regs[1] !== prev) begin errors++; $display("FAIL clrmid_nowrite got=%0h exp=%0h", regs[1], prev); end
    endtask

    task automatic test_halt();
        ir = 32'hD8000000;
        step(); step(); step();
        checks++; if (state !== 4'd4 || strb !== 15'h0 || Rout !== 16'h0) begin errors++; $display("FAIL halt_t3 got=%0h/%0h/%0h exp=4/0/0", state, strb, Rout); end
        step();
        for (int i = 0; i < 10; i++) begin
            checks++; if (state !== 4'd7 || run !== 1'b0) begin errors++; $display("FAIL halt_hold[%0d] got=%0h/%0b exp=7/0", i, state, run); end
            checks++; if (strb !== 15'h0 || Rin !== 16'h0 || Rout !== 16'h0) begin errors++; $display("FAIL halt_quiet[%0d] got=%0h/%0h/%0h exp=0/0/0", i, strb, Rin, Rout); end
            step();
        end
        clr = 1'b1;
        step();
        checks++; if (state !== 4'd0 || run !== 1'b1) begin errors++; $display("FAIL halt_clr got=%0h/%0b exp=0/1", state, run); end
        clr = 1'b0;
        step();
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL halt_restart got=%0h exp=1", state); end
    endtask

    task automatic test_back_to_back_wrap();
        ir = 32'h28918000;
        for (int n = 0; n < 15; n++) for (int c = 0; c < 6; c++) step();
        checks++; if (instr_count !== 4'd15 || state !== 4'd1) begin errors++; $display("FAIL wrap_pre got=%0d/%0h exp=15/1", instr_count, state); end
        for (int c = 0; c < 5; c++) step();
        checks++; if (state !== 4'd6 || instr_count !== 4'd15) begin errors++; $display("FAIL wrap_t5 got=%0h/%0d exp=6/15", state, instr_count); end
        step();
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", instr_count); end
    endtask

    initial begin
        test_reset();
        test_and_instr();
        test_sub_instr();
        test_t1_wait();
        test_nop();
        test_or_instr();
        test_clr_mid();
        test_halt();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
